// File: rtl/s7_iserdes_pkg.sv
// Shared types and helpers for the ISERDES frame-alignment controller.
package s7_iserdes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    // Frame-lane word expected from a typical 8-bit ADC frame clock.
    localparam logic [7:0] DEF_FRAME_PATTERN = 8'hF0;

    // Bits needed to hold values 0..max_val, i.e. clog2(max_val + 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= max_val) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/s7_iserdes_frame_align_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/s7_iserdes_frame_align.sv
// Frame-word alignment controller for the 7-series ISERDES: issues bitslip
// pulses until the frame lane matches FRAME_PATTERN, then monitors for loss.
module s7_iserdes_frame_align
    import s7_iserdes_pkg::*;
#(
    parameter int unsigned   DW            = 8,
    parameter logic [DW-1:0] FRAME_PATTERN = DW'(DEF_FRAME_PATTERN),
    parameter int unsigned   SETTLE_CYC    = 4,
    parameter int unsigned   MATCH_CNT     = 16,
    parameter int unsigned   MISS_LIMIT    = 4,
    parameter int unsigned   MAX_SLIPS     = 2 * DW
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          enable,
    input  logic [DW-1:0] frame_word,
    input  logic          frame_valid,
    output logic          bitslip,
    output logic          locked,
    output logic          align_err,
    output logic [7:0]    slip_count,
    output logic [7:0]    relock_count
);

    localparam int unsigned MW  = cnt_width(MATCH_CNT);
    localparam int unsigned MSW = cnt_width(MISS_LIMIT);
    localparam int unsigned TW  = cnt_width(SETTLE_CYC);

    localparam logic [MW-1:0]  MATCH_LAST  = MW'(MATCH_CNT - 1);
    localparam logic [MSW-1:0] MISS_LAST   = MSW'(MISS_LIMIT - 1);
    localparam logic [7:0]     SLIP_MAX    = 8'(MAX_SLIPS);
    localparam logic [TW-1:0]  SETTLE_LOAD = TW'(SETTLE_CYC);

    state_t         state_d, state_q;
    logic [TW-1:0]  timer_d, timer_q;
    logic           cmp_valid_d, cmp_valid_q;
    logic           cmp_match_d, cmp_match_q;
    logic           bitslip_d, bitslip_q;
    logic           locked_d, locked_q;
    logic           align_err_d, align_err_q;

    logic           slip_clr, slip_inc;
    logic           relock_clr, relock_inc;
    logic           match_clr, match_inc;
    logic           miss_clr, miss_inc;

    logic [7:0]     slip_cnt;
    logic [7:0]     relock_cnt;
    logic [MW-1:0]  match_cnt;
    logic [MSW-1:0] miss_cnt;

    // Compare stage: words are only accepted while CHECK or LOCKED is
    // active, so anything arriving during SLIP/SETTLE is discarded.
    always_comb begin
        cmp_valid_d = frame_valid && ((state_q == ST_CHECK) || (state_q == ST_LOCKED));
        cmp_match_d = (frame_word == FRAME_PATTERN);
    end

    // Compare register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmp_valid_q <= 1'b0;
            cmp_match_q <= 1'b0;
        end else begin
            cmp_valid_q <= cmp_valid_d;
            cmp_match_q <= cmp_match_d;
        end
    end

    // Next-state, counter controls and registered-output decode.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        slip_clr   = 1'b0;
        slip_inc   = 1'b0;
        relock_clr = 1'b0;
        relock_inc = 1'b0;
        match_clr  = 1'b0;
        match_inc  = 1'b0;
        miss_clr   = 1'b0;
        miss_inc   = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    slip_clr   = 1'b1;
                    relock_clr = 1'b1;
                    match_clr  = 1'b1;
                    state_d    = ST_CHECK;
                end
                ST_CHECK: begin
                    if (cmp_valid_q) begin
                        if (cmp_match_q) begin
                            match_inc = 1'b1;
                            if (match_cnt == MATCH_LAST) begin
                                state_d  = ST_LOCKED;
                                miss_clr = 1'b1;
                            end
                        end else begin
                            match_clr = 1'b1;
                            if (slip_cnt == SLIP_MAX) begin
                                state_d = ST_FAIL;
                            end else begin
                                // Counted on entry so slip_count moves with the pulse.
                                state_d  = ST_SLIP;
                                slip_inc = 1'b1;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    state_d = ST_SETTLE;
                    timer_d = SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (timer_q == '0) state_d = ST_CHECK;
                    else               timer_d = timer_q - TW'(1);
                end
                ST_LOCKED: begin
                    if (cmp_valid_q) begin
                        if (cmp_match_q) begin
                            miss_clr = 1'b1;
                        end else if (miss_cnt == MISS_LAST) begin
                            state_d    = ST_CHECK;
                            relock_inc = 1'b1;
                            slip_clr   = 1'b1;
                            match_clr  = 1'b1;
                        end else begin
                            miss_inc = 1'b1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        bitslip_d   = (state_d == ST_SLIP);
        locked_d    = (state_d == ST_LOCKED);
        align_err_d = (state_d == ST_FAIL);
    end

    // State, settle timer and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bitslip_q   <= 1'b0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitslip_q   <= bitslip_d;
            locked_q    <= locked_d;
            align_err_q <= align_err_d;
        end
    end

    sat_counter #(.W(8)) u_slip_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (slip_clr),
        .inc   (slip_inc),
        .count (slip_cnt)
    );

    sat_counter #(.W(8)) u_relock_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (relock_clr),
        .inc   (relock_inc),
        .count (relock_cnt)
    );

    sat_counter #(.W(MW)) u_match_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (match_clr),
        .inc   (match_inc),
        .count (match_cnt)
    );

    sat_counter #(.W(MSW)) u_miss_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (miss_clr),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

    assign bitslip      = bitslip_q;
    assign locked       = locked_q;
    assign align_err    = align_err_q;
    assign slip_count   = slip_cnt;
    assign relock_count = relock_cnt;

endmodule

// File: tb/tb_s7_iserdes_frame_align.sv
// Directed self-checking bench for s7_iserdes_frame_align.
module tb_s7_iserdes_frame_align;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       enable;
    logic [7:0] frame_word;
    logic       frame_valid;
    logic       bitslip;
    logic       locked;
    logic       align_err;
    logic [7:0] slip_count;
    logic [7:0] relock_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -100;
    logic prev_bs = 1'b0;
    logic rot_en = 1'b0;

    s7_iserdes_frame_align #(
        .DW            (8),
        .FRAME_PATTERN (8'hF0),
        .SETTLE_CYC    (4),
        .MATCH_CNT     (16),
        .MISS_LIMIT    (4),
        .MAX_SLIPS     (16)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .enable       (enable),
        .frame_word   (frame_word),
        .frame_valid  (frame_valid),
        .bitslip      (bitslip),
        .locked       (locked),
        .align_err    (align_err),
        .slip_count   (slip_count),
        .relock_count (relock_count)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // One clock: sample 1 time unit after the edge, track bitslip pulses and
    // rotate the modelled deserializer output on each observed pulse.
    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (bitslip === 1'b1) begin
            n_cmp++;
            if (prev_bs === 1'b1 || (cyc - last_pulse) < 5) begin
                $display("FAIL bitslip_spacing: got gap %0d, need >= 5 and no back-to-back", cyc - last_pulse);
                n_err++;
            end
            pulses++;
            last_pulse = cyc;
            if (rot_en) frame_word = {frame_word[6:0], frame_word[7]};
        end
        prev_bs = bitslip;
    endtask

    task automatic test_reset();
        sys_rst_n   = 1'b0;
        enable      = 1'b0;
        frame_word  = 8'h00;
        frame_valid = 1'b0;
        #3;
        n_cmp++;
        if ({bitslip, locked, align_err, slip_count, relock_count} !== 19'd0) begin
            $display("FAIL reset_outputs: got %b, need all zero", {bitslip, locked, align_err, slip_count, relock_count});
            n_err++;
        end
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if ({bitslip, locked, align_err, slip_count} !== 11'd0) begin
            $display("FAIL idle_after_reset: got %b, need all zero", {bitslip, locked, align_err, slip_count});
            n_err++;
        end
    endtask

    task automatic test_aligned();
        int lock_at;
        lock_at = -1;
        pulses = 0;
        frame_word = 8'hF0;
        frame_valid = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (locked === 1'b1 && lock_at < 0) lock_at = k;
        end
        n_cmp++;
        if (lock_at !== 18) begin
            $display("FAIL aligned_lock_cycle: got %0d, need 18", lock_at);
            n_err++;
        end
        n_cmp++;
        if (pulses !== 0 || slip_count !== 8'd0) begin
            $display("FAIL aligned_no_slip: got pulses=%0d slip_count=%0d, need 0/0", pulses, slip_count);
            n_err++;
        end
    endtask

    task automatic test_loss_of_lock();
        int bad;
        pulses = 0;
        n_cmp++;
        if (locked !== 1'b1) begin
            $display("FAIL loss_precondition: got locked=%b, need 1", locked);
            n_err++;
        end
        // three-word glitch, below the miss limit
        frame_word = 8'h00;
        step(); step(); step();
        frame_word = 8'hF0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (locked !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            $display("FAIL glitch_holds_lock: got %0d unlocked cycles, need 0", bad);
            n_err++;
        end
        // four consecutive misses
        frame_word = 8'h00;
        step(); step(); step(); step();
        frame_word = 8'hF0;
        n_cmp++;
        if (locked !== 1'b1) begin
            $display("FAIL lock_before_4th_miss: got locked=%b, need 1", locked);
            n_err++;
        end
        step();
        n_cmp++;
        if (locked !== 1'b0 || relock_count !== 8'd1) begin
            $display("FAIL loss_detected: got locked=%b relock_count=%0d, need 0/1", locked, relock_count);
            n_err++;
        end
        for (int i = 0; i < 15; i++) step();
        n_cmp++;
        if (locked !== 1'b0) begin
            $display("FAIL relock_early: got locked=%b after 15 cycles, need 0", locked);
            n_err++;
        end
        step();
        n_cmp++;
        if (locked !== 1'b1 || pulses !== 0) begin
            $display("FAIL relock: got locked=%b pulses=%0d, need 1/0", locked, pulses);
            n_err++;
        end
        enable = 1'b0;
        step();
        n_cmp++;
        if (locked !== 1'b0 || relock_count !== 8'd1) begin
            $display("FAIL disable_in_locked: got locked=%b relock_count=%0d, need 0/1", locked, relock_count);
            n_err++;
        end
    endtask

    task automatic test_rotated();
        int lock_at;
        lock_at = -1;
        enable = 1'b0;
        step(); step();
        pulses = 0;
        last_pulse = -100;
        rot_en = 1'b1;
        frame_word = 8'h1E;
        frame_valid = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (locked === 1'b1 && lock_at < 0) lock_at = k;
        end
        rot_en = 1'b0;
        n_cmp++;
        if (pulses !== 3 || slip_count !== 8'd3) begin
            $display("FAIL rotated_slips: got pulses=%0d slip_count=%0d, need 3/3", pulses, slip_count);
            n_err++;
        end
        n_cmp++;
        if (lock_at !== 42 || frame_word !== 8'hF0) begin
            $display("FAIL rotated_lock: got lock_at=%0d word=%h, need 42/f0", lock_at, frame_word);
            n_err++;
        end
        n_cmp++;
        if (relock_count !== 8'd0) begin
            $display("FAIL relock_cleared: got %0d, need 0", relock_count);
            n_err++;
        end
    endtask

    task automatic test_never_match();
        int err_at;
        err_at = -1;
        enable = 1'b0;
        step(); step();
        pulses = 0;
        last_pulse = -100;
        frame_word = 8'hAA;
        frame_valid = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (align_err === 1'b1 && err_at < 0) err_at = k;
        end
        n_cmp++;
        if (pulses !== 16 || slip_count !== 8'd16) begin
            $display("FAIL never_match_slips: got pulses=%0d slip_count=%0d, need 16/16", pulses, slip_count);
            n_err++;
        end
        n_cmp++;
        if (err_at !== 131 || align_err !== 1'b1 || locked !== 1'b0) begin
            $display("FAIL align_err: got err_at=%0d align_err=%b locked=%b, need 131/1/0", err_at, align_err, locked);
            n_err++;
        end
        enable = 1'b0;
        step();
        n_cmp++;
        if (align_err !== 1'b0 || slip_count !== 8'd16) begin
            $display("FAIL disable_clears_err: got align_err=%b slip_count=%0d, need 0/16", align_err, slip_count);
            n_err++;
        end
        step();
        enable = 1'b1;
        step();
        n_cmp++;
        if (slip_count !== 8'd0 || align_err !== 1'b0) begin
            $display("FAIL reenable_restart: got slip_count=%0d align_err=%b, need 0/0", slip_count, align_err);
            n_err++;
        end
    endtask

    task automatic test_gaps();
        int lock_at;
        lock_at = -1;
        enable = 1'b0;
        step(); step();
        pulses = 0;
        frame_word = 8'hF0;
        frame_valid = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            frame_valid = (k % 2 == 0);
            if (locked === 1'b1 && lock_at < 0) lock_at = k;
        end
        frame_valid = 1'b1;
        n_cmp++;
        if (lock_at !== 34 || pulses !== 0) begin
            $display("FAIL gaps_lock: got lock_at=%0d pulses=%0d, need 34/0", lock_at, pulses);
            n_err++;
        end
    endtask

    task automatic test_async_reset();
        int slip_at;
        slip_at = -1;
        enable = 1'b0;
        step(); step();
        frame_word = 8'hAA;
        frame_valid = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 10 && slip_at < 0; k++) begin
            step();
            if (bitslip === 1'b1) slip_at = k;
        end
        n_cmp++;
        if (slip_at !== 3 || slip_count !== 8'd1) begin
            $display("FAIL first_slip: got at=%0d slip_count=%0d, need 3/1", slip_at, slip_count);
            n_err++;
        end
        sys_rst_n = 1'b0;
        enable = 1'b0;
        #1;
        n_cmp++;
        if ({bitslip, locked, align_err, slip_count, relock_count} !== 19'd0) begin
            $display("FAIL async_reset: got %b, need all zero", {bitslip, locked, align_err, slip_count, relock_count});
            n_err++;
        end
        #2 sys_rst_n = 1'b1;
        prev_bs = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (pulses !== 0 || slip_count !== 8'd0 || locked !== 1'b0) begin
            $display("FAIL idle_after_async: got pulses=%0d slip_count=%0d locked=%b, need 0/0/0", pulses, slip_count, locked);
            n_err++;
        end
        slip_at = -1;
        last_pulse = -100;
        enable = 1'b1;
        for (int k = 1; k <= 10 && slip_at < 0; k++) begin
            step();
            if (bitslip === 1'b1) slip_at = k;
        end
        n_cmp++;
        if (slip_at !== 3) begin
            $display("FAIL restart_after_async: got first slip at %0d, need 3", slip_at);
            n_err++;
        end
        enable = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_loss_of_lock();
        test_rotated();
        test_never_match();
        test_gaps();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
